// File: rtl/axi_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// axi_lite_cmd_master
//
// Single-outstanding AXI4-Lite master. A simple command stream (write/read,
// address, data, strobes) is turned into one AXI4-Lite transaction at a time,
// and its result comes back on a response stream. A per-transaction hang
// timeout abandons a transaction the slave never finishes. Two saturating
// statistics counters track completed responses and error responses.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESET    clock and asynchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_write, cmd_addr,        command fields (1 = write, 0 = read)
//   cmd_wdata, cmd_wstrb
//   rsp_valid/rsp_ready         response handshake
//   rsp_write, rsp_rdata,       response fields; rsp_rdata is 0 for writes
//   rsp_resp, rsp_timeout       and on timeout, rsp_resp is 2'b10 on timeout
//   stat_txn_count              completed responses (saturating)
//   stat_err_count              responses with error or timeout (saturating)
//   M_AXI_AW*/W*/B*/AR*/R*      AXI4-Lite master channels, PROT tied to 0
//
// Every output is a flop. The combinational process computes the next value
// of every register from the current state and inputs.
// ---------------------------------------------------------------------------
module axi_lite_cmd_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_timeout,
    output logic [15:0]                       stat_txn_count,
    output logic [15:0]                       stat_err_count,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_B,
        S_RD_AR,
        S_RD_R,
        S_RSP
    } state_t;

    state_t          r_state,       w_state;
    logic            r_cmd_ready,   w_cmd_ready;
    logic            r_awvalid,     w_awvalid;
    logic            r_wvalid,      w_wvalid;
    logic            r_bready,      w_bready;
    logic            r_arvalid,     w_arvalid;
    logic            r_rready,      w_rready;
    logic [AW-1:0]   r_addr,        w_addr;
    logic [DW-1:0]   r_wdata,       w_wdata;
    logic [SW-1:0]   r_wstrb,       w_wstrb;
    logic            r_write,       w_write;
    logic            r_rsp_valid,   w_rsp_valid;
    logic            r_rsp_write,   w_rsp_write;
    logic [DW-1:0]   r_rsp_rdata,   w_rsp_rdata;
    logic [1:0]      r_rsp_resp,    w_rsp_resp;
    logic            r_rsp_timeout, w_rsp_timeout;
    logic [TW-1:0]   r_timer,       w_timer;
    logic [15:0]     r_txn_count,   w_txn_count;
    logic [15:0]     r_err_count,   w_err_count;
    logic            w_active;
    logic            w_timeout;

    // The timer holds the number of cycles already spent in the current
    // transaction, so it fires in the cycle TIMEOUT_CYCLES after accept and
    // the response appears one cycle later.
    assign w_active  = (r_state == S_WR) || (r_state == S_WR_B) ||
                       (r_state == S_RD_AR) || (r_state == S_RD_R);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && w_active && (r_timer == TIMER_LAST);

    // Next-state and next-output logic. Every register keeps its value unless
    // the current state says otherwise; handshake flags are computed for the
    // next cycle so the AXI outputs come straight from flops.
    always_comb begin
        w_state       = r_state;
        w_cmd_ready   = r_cmd_ready;
        w_awvalid     = r_awvalid;
        w_wvalid      = r_wvalid;
        w_bready      = r_bready;
        w_arvalid     = r_arvalid;
        w_rready      = r_rready;
        w_addr        = r_addr;
        w_wdata       = r_wdata;
        w_wstrb       = r_wstrb;
        w_write       = r_write;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_write   = r_rsp_write;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_resp    = r_rsp_resp;
        w_rsp_timeout = r_rsp_timeout;
        w_timer       = r_timer;
        w_txn_count   = r_txn_count;
        w_err_count   = r_err_count;

        if (w_active) begin
            w_timer = r_timer + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                // cmd_ready is low only in the first cycle after reset release
                w_cmd_ready = 1'b1;
                if (cmd_valid && r_cmd_ready) begin
                    w_cmd_ready = 1'b0;
                    w_addr      = cmd_addr;
                    w_wdata     = cmd_wdata;
                    w_wstrb     = cmd_wstrb;
                    w_write     = cmd_write;
                    w_timer     = '0;
                    if (cmd_write) begin
                        w_state   = S_WR;
                        w_awvalid = 1'b1;
                        w_wvalid  = 1'b1;
                    end else begin
                        w_state   = S_RD_AR;
                        w_arvalid = 1'b1;
                    end
                end
            end
            S_WR: begin
                // Each valid drops on its own handshake; a ready seen after
                // its valid already dropped has no effect.
                if (M_AXI_AWREADY) begin
                    w_awvalid = 1'b0;
                end
                if (M_AXI_WREADY) begin
                    w_wvalid = 1'b0;
                end
                if (!w_awvalid && !w_wvalid) begin
                    w_state  = S_WR_B;
                    w_bready = 1'b1;
                end
            end
            S_WR_B: begin
                if (M_AXI_BVALID) begin
                    w_state       = S_RSP;
                    w_bready      = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_rsp_write   = 1'b1;
                    w_rsp_rdata   = '0;
                    w_rsp_resp    = M_AXI_BRESP;
                    w_rsp_timeout = 1'b0;
                end
            end
            S_RD_AR: begin
                if (M_AXI_ARREADY) begin
                    w_state   = S_RD_R;
                    w_arvalid = 1'b0;
                    w_rready  = 1'b1;
                end
            end
            S_RD_R: begin
                if (M_AXI_RVALID) begin
                    w_state       = S_RSP;
                    w_rready      = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_rsp_write   = 1'b0;
                    w_rsp_rdata   = M_AXI_RDATA;
                    w_rsp_resp    = M_AXI_RRESP;
                    w_rsp_timeout = 1'b0;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    w_state     = S_IDLE;
                    w_rsp_valid = 1'b0;
                    w_cmd_ready = 1'b1;
                    if (r_txn_count != 16'hFFFF) begin
                        w_txn_count = r_txn_count + 16'd1;
                    end
                    if (((r_rsp_resp != 2'b00) || r_rsp_timeout) && (r_err_count != 16'hFFFF)) begin
                        w_err_count = r_err_count + 16'd1;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Hang recovery overrides whatever the slave did this cycle; any
        // beat it produces later is simply never looked at.
        if (w_timeout) begin
            w_state       = S_RSP;
            w_awvalid     = 1'b0;
            w_wvalid      = 1'b0;
            w_bready      = 1'b0;
            w_arvalid     = 1'b0;
            w_rready      = 1'b0;
            w_rsp_valid   = 1'b1;
            w_rsp_write   = r_write;
            w_rsp_rdata   = '0;
            w_rsp_resp    = 2'b10;
            w_rsp_timeout = 1'b1;
        end
    end

    // State and output registers; reset clears everything immediately,
    // including cmd_ready, which stays low until the first clock after release.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wstrb       <= '0;
            r_write       <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
            r_timer       <= '0;
            r_txn_count   <= 16'd0;
            r_err_count   <= 16'd0;
        end else begin
            r_state       <= w_state;
            r_cmd_ready   <= w_cmd_ready;
            r_awvalid     <= w_awvalid;
            r_wvalid      <= w_wvalid;
            r_bready      <= w_bready;
            r_arvalid     <= w_arvalid;
            r_rready      <= w_rready;
            r_addr        <= w_addr;
            r_wdata       <= w_wdata;
            r_wstrb       <= w_wstrb;
            r_write       <= w_write;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_write   <= w_rsp_write;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_resp    <= w_rsp_resp;
            r_rsp_timeout <= w_rsp_timeout;
            r_timer       <= w_timer;
            r_txn_count   <= w_txn_count;
            r_err_count   <= w_err_count;
        end
    end

    assign cmd_ready      = r_cmd_ready;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_write      = r_rsp_write;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_resp       = r_rsp_resp;
    assign rsp_timeout    = r_rsp_timeout;
    assign stat_txn_count = r_txn_count;
    assign stat_err_count = r_err_count;
    assign M_AXI_AWADDR   = r_addr;
    assign M_AXI_AWPROT   = 3'b000;
    assign M_AXI_AWVALID  = r_awvalid;
    assign M_AXI_WDATA    = r_wdata;
    assign M_AXI_WSTRB    = r_wstrb;
    assign M_AXI_WVALID   = r_wvalid;
    assign M_AXI_BREADY   = r_bready;
    assign M_AXI_ARADDR   = r_addr;
    assign M_AXI_ARPROT   = 3'b000;
    assign M_AXI_ARVALID  = r_arvalid;
    assign M_AXI_RREADY   = r_rready;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_cmd_master
//
// Drives axi_lite_cmd_master against a small behavioural register-file slave
// with a few misbehaviour knobs (AW stall, silent slave, SLVERR, withheld B).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_axi_lite_cmd_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic        cmdWrite = 1'b0;
    logic [11:0] cmdAddr  = '0;
    logic [31:0] cmdWdata = '0;
    logic [3:0]  cmdWstrb = '0;
    logic        rspValid;
    logic        rspReady = 1'b1;
    logic        rspWrite;
    logic [31:0] rspRdata;
    logic [1:0]  rspResp;
    logic        rspTimeout;
    logic [15:0] statTxn;
    logic [15:0] statErr;

    logic [11:0] mAwaddr;
    logic [2:0]  mAwprot;
    logic        mAwvalid;
    logic [31:0] mWdata;
    logic [3:0]  mWstrb;
    logic        mWvalid;
    logic        mBready;
    logic [11:0] mAraddr;
    logic [2:0]  mArprot;
    logic        mArvalid;
    logic        mRready;

    logic        sAwready;
    logic        sWready;
    logic        sBvalid;
    logic [1:0]  sBresp;
    logic        sArready;
    logic        sRvalid;
    logic [31:0] sRdata;

    // Slave behaviour knobs
    logic        silentMode = 1'b0;
    logic        awStall    = 1'b0;
    logic        noB        = 1'b0;
    logic        slvErr     = 1'b0;

    logic [31:0] mem [0:1023];
    logic        wGot;
    logic [31:0] latchData;
    logic [3:0]  latchStrb;
    int          stallCnt;
    int          wBeats = 0;
    int          awAlone = 0;

    int          nChecks = 0;
    int          nFails  = 0;

    always #5 clk = ~clk;

    axi_lite_cmd_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(12),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .M_AXI_ACLK(clk),
        .M_AXI_ARESET(rst),
        .cmd_valid(cmdValid),
        .cmd_ready(cmdReady),
        .cmd_write(cmdWrite),
        .cmd_addr(cmdAddr),
        .cmd_wdata(cmdWdata),
        .cmd_wstrb(cmdWstrb),
        .rsp_valid(rspValid),
        .rsp_ready(rspReady),
        .rsp_write(rspWrite),
        .rsp_rdata(rspRdata),
        .rsp_resp(rspResp),
        .rsp_timeout(rspTimeout),
        .stat_txn_count(statTxn),
        .stat_err_count(statErr),
        .M_AXI_AWADDR(mAwaddr),
        .M_AXI_AWPROT(mAwprot),
        .M_AXI_AWVALID(mAwvalid),
        .M_AXI_AWREADY(sAwready),
        .M_AXI_WDATA(mWdata),
        .M_AXI_WSTRB(mWstrb),
        .M_AXI_WVALID(mWvalid),
        .M_AXI_WREADY(sWready),
        .M_AXI_BRESP(sBresp),
        .M_AXI_BVALID(sBvalid),
        .M_AXI_BREADY(mBready),
        .M_AXI_ARADDR(mAraddr),
        .M_AXI_ARPROT(mArprot),
        .M_AXI_ARVALID(mArvalid),
        .M_AXI_ARREADY(sArready),
        .M_AXI_RDATA(sRdata),
        .M_AXI_RRESP(2'b00),
        .M_AXI_RVALID(sRvalid),
        .M_AXI_RREADY(mRready)
    );

    // Register-file slave: raises AWREADY and WREADY together one cycle after
    // seeing both valids, BVALID/RVALID one cycle after the address handshake.
    // In stall mode W is taken alone and AWREADY follows 3 cycles later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sAwready <= 1'b0;
            sWready  <= 1'b0;
            sBvalid  <= 1'b0;
            sBresp   <= 2'b00;
            sArready <= 1'b0;
            sRvalid  <= 1'b0;
            sRdata   <= '0;
            wGot     <= 1'b0;
            stallCnt <= 0;
        end else begin
            sAwready <= 1'b0;
            sWready  <= 1'b0;
            sArready <= 1'b0;
            if (!silentMode) begin
                if (!awStall) begin
                    if (mAwvalid && mWvalid && !sAwready && !sWready && !sBvalid) begin
                        sAwready <= 1'b1;
                        sWready  <= 1'b1;
                    end
                    if (mAwvalid && sAwready && mWvalid && sWready) begin
                        for (int b = 0; b < 4; b++) begin
                            if (mWstrb[b]) mem[mAwaddr[11:2]][8*b +: 8] <= mWdata[8*b +: 8];
                        end
                        wBeats <= wBeats + 1;
                        if (!noB) begin
                            sBvalid <= 1'b1;
                            sBresp  <= slvErr ? 2'b10 : 2'b00;
                        end
                    end
                end else begin
                    if (stallCnt != 0) stallCnt <= stallCnt - 1;
                    if (stallCnt == 1) sAwready <= 1'b1;
                    if (mWvalid && !sWready && !wGot) sWready <= 1'b1;
                    if (mWvalid && sWready) begin
                        wGot      <= 1'b1;
                        latchData <= mWdata;
                        latchStrb <= mWstrb;
                        stallCnt  <= 2;
                        wBeats    <= wBeats + 1;
                    end
                    if (mAwvalid && sAwready && wGot) begin
                        for (int b = 0; b < 4; b++) begin
                            if (latchStrb[b]) mem[mAwaddr[11:2]][8*b +: 8] <= latchData[8*b +: 8];
                        end
                        wGot    <= 1'b0;
                        sBvalid <= 1'b1;
                        sBresp  <= 2'b00;
                    end
                end
                if (sBvalid && mBready) sBvalid <= 1'b0;
                if (mArvalid && !sArready && !sRvalid) sArready <= 1'b1;
                if (mArvalid && sArready) begin
                    sRvalid <= 1'b1;
                    sRdata  <= mem[mAraddr[11:2]];
                end
                if (sRvalid && mRready) sRvalid <= 1'b0;
            end
        end
    end

    // Counts cycles where AWVALID is up without WVALID
    always @(negedge clk) begin
        if (mAwvalid && !mWvalid) awAlone <= awAlone + 1;
    end

    // Issues one command from a falling edge and returns at the falling edge
    // where rsp_valid is first seen; lat counts cycles after the accept cycle.
    task automatic doCmd(input logic w, input logic [11:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int lat);
        int waitCnt;
        waitCnt = 0;
        while (!cmdReady && waitCnt < 50) begin
            @(negedge clk);
            waitCnt++;
        end
        cmdValid = 1'b1;
        cmdWrite = w;
        cmdAddr  = a;
        cmdWdata = d;
        cmdWstrb = s;
        @(negedge clk);
        cmdValid = 1'b0;
        lat = 1;
        while (!rspValid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Reset values while reset is held, then cmd_ready after release
    task automatic test_reset;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        nChecks++;
        if (cmdReady !== 1'b0) begin nFails++; $display("[TB] FAIL rst_cmd_ready: got %b expected 0", cmdReady); end
        nChecks++;
        if ({mAwvalid, mWvalid, mBready, mArvalid, mRready} !== 5'b0) begin
            nFails++; $display("[TB] FAIL rst_axi_hs: got %b expected 00000", {mAwvalid, mWvalid, mBready, mArvalid, mRready});
        end
        nChecks++;
        if ({mAwaddr, mWdata, mWstrb} !== 48'h0) begin
            nFails++; $display("[TB] FAIL rst_axi_data: got %h expected 0", {mAwaddr, mWdata, mWstrb});
        end
        nChecks++;
        if ({rspValid, rspWrite, rspRdata, rspResp, rspTimeout} !== 37'h0) begin
            nFails++; $display("[TB] FAIL rst_rsp: got %h expected 0", {rspValid, rspWrite, rspRdata, rspResp, rspTimeout});
        end
        nChecks++;
        if ({statTxn, statErr} !== 32'h0) begin nFails++; $display("[TB] FAIL rst_stats: got %h expected 0", {statTxn, statErr}); end
        rst = 1'b0;
        @(negedge clk);
        nChecks++;
        if (cmdReady !== 1'b1) begin nFails++; $display("[TB] FAIL rst_release_ready: got %b expected 1", cmdReady); end
    endtask

    // Write then read back on an idle slave, with latency and spacing
    task automatic test_write_read;
        int lat;
        doCmd(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, lat);
        nChecks++;
        if (lat !== 4) begin nFails++; $display("[TB] FAIL wr_latency: got %0d expected 4", lat); end
        nChecks++;
        if ({rspWrite, rspResp, rspTimeout, rspRdata} !== {1'b1, 2'b00, 1'b0, 32'h0}) begin
            nFails++; $display("[TB] FAIL wr_rsp: got w=%b resp=%b to=%b rd=%h expected w=1 resp=00 to=0 rd=0", rspWrite, rspResp, rspTimeout, rspRdata);
        end
        @(negedge clk);
        nChecks++;
        if ({cmdReady, rspValid} !== 2'b10) begin
            nFails++; $display("[TB] FAIL next_cmd_ready: got ready=%b rsp_valid=%b expected 1 0", cmdReady, rspValid);
        end
        doCmd(1'b0, 12'h004, 32'h0, 4'h0, lat);
        nChecks++;
        if (lat !== 4) begin nFails++; $display("[TB] FAIL rd_latency: got %0d expected 4", lat); end
        nChecks++;
        if ({rspWrite, rspResp, rspRdata} !== {1'b0, 2'b00, 32'hDEADBEEF}) begin
            nFails++; $display("[TB] FAIL rd_rsp: got w=%b resp=%b rd=%h expected w=0 resp=00 rd=deadbeef", rspWrite, rspResp, rspRdata);
        end
        @(negedge clk);
        nChecks++;
        if ({statTxn, statErr} !== {16'd2, 16'd0}) begin
            nFails++; $display("[TB] FAIL wr_rd_stats: got txn=%0d err=%0d expected 2 0", statTxn, statErr);
        end
    endtask

    // Partial-strobe write over all-ones
    task automatic test_strobe;
        int lat;
        doCmd(1'b1, 12'h008, 32'hFFFFFFFF, 4'hF, lat);
        @(negedge clk);
        doCmd(1'b1, 12'h008, 32'h11223344, 4'h5, lat);
        @(negedge clk);
        doCmd(1'b0, 12'h008, 32'h0, 4'h0, lat);
        nChecks++;
        if (rspRdata !== 32'hFF22FF44) begin nFails++; $display("[TB] FAIL strobe_readback: got %h expected ff22ff44", rspRdata); end
        @(negedge clk);
    endtask

    // AWREADY held off 3 cycles after the W handshake
    task automatic test_aw_stall;
        int lat;
        int beats0;
        int alone0;
        awStall = 1'b1;
        beats0  = wBeats;
        alone0  = awAlone;
        doCmd(1'b1, 12'h00C, 32'hCAFEF00D, 4'hF, lat);
        nChecks++;
        if (lat !== 7) begin nFails++; $display("[TB] FAIL stall_latency: got %0d expected 7", lat); end
        nChecks++;
        if (rspResp !== 2'b00) begin nFails++; $display("[TB] FAIL stall_resp: got %b expected 00", rspResp); end
        nChecks++;
        if (wBeats - beats0 !== 1) begin nFails++; $display("[TB] FAIL stall_w_beats: got %0d expected 1", wBeats - beats0); end
        nChecks++;
        if (awAlone - alone0 !== 3) begin nFails++; $display("[TB] FAIL stall_aw_alone: got %0d expected 3", awAlone - alone0); end
        @(negedge clk);
        awStall = 1'b0;
        doCmd(1'b0, 12'h00C, 32'h0, 4'h0, lat);
        nChecks++;
        if (rspRdata !== 32'hCAFEF00D) begin nFails++; $display("[TB] FAIL stall_readback: got %h expected cafef00d", rspRdata); end
        @(negedge clk);
    endtask

    // Silent slave: the transaction is abandoned after TO cycles
    task automatic test_timeout;
        int lat;
        silentMode = 1'b1;
        doCmd(1'b1, 12'h010, 32'h12345678, 4'hF, lat);
        nChecks++;
        if (lat !== TO + 1) begin nFails++; $display("[TB] FAIL to_latency: got %0d expected %0d", lat, TO + 1); end
        nChecks++;
        if ({rspResp, rspTimeout, rspRdata} !== {2'b10, 1'b1, 32'h0}) begin
            nFails++; $display("[TB] FAIL to_rsp: got resp=%b to=%b rd=%h expected resp=10 to=1 rd=0", rspResp, rspTimeout, rspRdata);
        end
        nChecks++;
        if ({mAwvalid, mWvalid, mBready, mArvalid, mRready} !== 5'b0) begin
            nFails++; $display("[TB] FAIL to_axi_idle: got %b expected 00000", {mAwvalid, mWvalid, mBready, mArvalid, mRready});
        end
        @(negedge clk);
        silentMode = 1'b0;
        nChecks++;
        if ({statTxn, statErr} !== {16'd8, 16'd1}) begin
            nFails++; $display("[TB] FAIL to_stats: got txn=%0d err=%0d expected 8 1", statTxn, statErr);
        end
    endtask

    // SLVERR on B is passed through and counted as an error
    task automatic test_slverr;
        int lat;
        slvErr = 1'b1;
        doCmd(1'b1, 12'h014, 32'h0BADF00D, 4'hF, lat);
        nChecks++;
        if ({rspResp, rspTimeout} !== {2'b10, 1'b0}) begin
            nFails++; $display("[TB] FAIL slverr_rsp: got resp=%b to=%b expected resp=10 to=0", rspResp, rspTimeout);
        end
        @(negedge clk);
        slvErr = 1'b0;
        nChecks++;
        if ({statTxn, statErr} !== {16'd9, 16'd2}) begin
            nFails++; $display("[TB] FAIL slverr_stats: got txn=%0d err=%0d expected 9 2", statTxn, statErr);
        end
    endtask

    // Back-pressure on the response, with the next command already waiting
    task automatic test_rsp_hold;
        int lat;
        int waitCnt;
        rspReady = 1'b0;
        doCmd(1'b0, 12'h004, 32'h0, 4'h0, lat);
        nChecks++;
        if (lat !== 4) begin nFails++; $display("[TB] FAIL hold_latency: got %0d expected 4", lat); end
        cmdValid = 1'b1;
        cmdWrite = 1'b1;
        cmdAddr  = 12'h018;
        cmdWdata = 32'hA5A5A5A5;
        cmdWstrb = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            nChecks++;
            if ({rspValid, rspWrite, rspResp, rspRdata, cmdReady} !== {1'b1, 1'b0, 2'b00, 32'hDEADBEEF, 1'b0}) begin
                nFails++;
                $display("[TB] FAIL hold_stable[%0d]: got v=%b w=%b resp=%b rd=%h ready=%b expected v=1 w=0 resp=00 rd=deadbeef ready=0",
                         i, rspValid, rspWrite, rspResp, rspRdata, cmdReady);
            end
        end
        rspReady = 1'b1;
        @(negedge clk);
        nChecks++;
        if ({cmdReady, rspValid} !== 2'b10) begin
            nFails++; $display("[TB] FAIL hold_release: got ready=%b rsp_valid=%b expected 1 0", cmdReady, rspValid);
        end
        @(negedge clk);
        cmdValid = 1'b0;
        nChecks++;
        if ({mAwvalid, mWvalid} !== 2'b11) begin
            nFails++; $display("[TB] FAIL hold_accept: got aw=%b w=%b expected 1 1", mAwvalid, mWvalid);
        end
        waitCnt = 0;
        while (!rspValid && waitCnt < 40) begin
            @(negedge clk);
            waitCnt++;
        end
        nChecks++;
        if ({rspValid, rspWrite, rspResp} !== {1'b1, 1'b1, 2'b00}) begin
            nFails++; $display("[TB] FAIL hold_next_rsp: got v=%b w=%b resp=%b expected 1 1 00", rspValid, rspWrite, rspResp);
        end
        @(negedge clk);
        nChecks++;
        if (statTxn !== 16'd11) begin nFails++; $display("[TB] FAIL hold_stats: got txn=%0d expected 11", statTxn); end
    endtask

    // Reset while waiting for B: everything clears at once
    task automatic test_reset_mid;
        int waitCnt;
        noB      = 1'b1;
        cmdValid = 1'b1;
        cmdWrite = 1'b1;
        cmdAddr  = 12'h01C;
        cmdWdata = 32'h55AA55AA;
        cmdWstrb = 4'hF;
        @(negedge clk);
        cmdValid = 1'b0;
        waitCnt  = 0;
        while (!mBready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        nChecks++;
        if (mBready !== 1'b1) begin nFails++; $display("[TB] FAIL mid_reach_wr_b: got %b expected 1", mBready); end
        rst = 1'b1;
        #1;
        nChecks++;
        if ({cmdReady, mAwvalid, mWvalid, mBready, mArvalid, mRready, rspValid} !== 7'b0) begin
            nFails++; $display("[TB] FAIL mid_rst_hs: got %b expected 0000000", {cmdReady, mAwvalid, mWvalid, mBready, mArvalid, mRready, rspValid});
        end
        nChecks++;
        if ({mAwaddr, mWdata, mWstrb, rspRdata, rspResp, rspTimeout, rspWrite} !== 84'h0) begin
            nFails++; $display("[TB] FAIL mid_rst_data: got %h expected 0", {mAwaddr, mWdata, mWstrb, rspRdata, rspResp, rspTimeout, rspWrite});
        end
        nChecks++;
        if ({statTxn, statErr} !== 32'h0) begin nFails++; $display("[TB] FAIL mid_rst_stats: got %h expected 0", {statTxn, statErr}); end
        noB = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nChecks++;
            if (rspValid !== 1'b0) begin nFails++; $display("[TB] FAIL mid_no_rsp[%0d]: got %b expected 0", i, rspValid); end
        end
        nChecks++;
        if ({cmdReady, statTxn} !== {1'b1, 16'd0}) begin
            nFails++; $display("[TB] FAIL mid_after: got ready=%b txn=%0d expected 1 0", cmdReady, statTxn);
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_strobe;
        test_aw_stall;
        test_timeout;
        test_slverr;
        test_rsp_hold;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Last-resort guard in case something hangs outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

Single-outstanding AXI4-Lite master that turns a simple command/response stream into AXI4-Lite read and write transactions. It sits directly upstream of the register file slave and drives its AXI port from an internal command source, such as the PCIe-side control path or a debug/test sequencer. It also provides a hang timeout and saturating transaction and error statistics.

## Interface
- C_M_AXI_DATA_WIDTH, 32, data width (only 32 supported)
- C_M_AXI_ADDR_WIDTH, 12, byte address width; matches the slave's address width
- TIMEOUT_CYCLES, 1024, cycles allowed per transaction after command accept; 0 disables the timeout
- M_AXI_ACLK  in  1  the only clock; every port is synchronous to it
- M_AXI_ARESET  in  1  reset, asynchronous assert, active-high
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address
- cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data
- cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  byte strobes
- rsp_valid / rsp_ready  out / in  1  response handshake
- rsp_write  out  1  echoes cmd_write
- rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP; 2'b10 on timeout
- rsp_timeout  out  1  transaction abandoned by the timeout
- stat_txn_count  out  16  completed responses, saturating
- stat_err_count  out  16  responses with resp≠0 or timeout, saturating
- M_AXI_AW*/W*/B*/AR*/R*: standard AXI4-Lite master channels
  - AWPROT and ARPROT are tied to 3'b000.

## Operation
- FSM states: IDLE, WR (AW+W), WR_B, RD_AR, RD_R, RSP.
- IDLE
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register addr, wdata, wstrb and write.
  - Write: go to WR. Read: go to RD_AR. Clear the timeout counter.
- WR
  - AWVALID and WVALID are asserted together in the same cycle. This is mandatory: the slave raises AWREADY only when it sees both valids.
  - Each valid drops independently after its own handshake.
  - Go to WR_B once both handshakes are done. Both may complete in the same cycle or in different cycles.
- WR_B
  - BREADY=1.
  - On BVALID, capture BRESP, set rdata=0, go to RSP.
- RD_AR
  - ARVALID=1 until ARREADY, then go to RD_R.
- RD_R
  - RREADY=1.
  - On RVALID, capture RDATA and RRESP, go to RSP.
- RSP
  - rsp_valid=1, response fields held stable.
  - On rsp_ready, go to IDLE. The stat counters increment on this handshake.
- Timeout
  - The counter runs in WR, WR_B, RD_AR and RD_R.
  - On reaching TIMEOUT_CYCLES: drop all AXI valids and readies, go to RSP with rsp_resp=2'b10, rsp_timeout=1, rdata=0.
  - This is a debug recovery path only; any late slave beat is ignored.
- No AXI valid or ready is high outside its own state.
- Commands are never accepted outside IDLE, so there is never more than one transaction outstanding.
- Counters saturate at 16'hFFFF and never wrap.

## Timing
- Reset values
  - State IDLE.
  - cmd_ready=1 after reset is released; 0 while M_AXI_ARESET is high.
  - All AXI valids and readies 0; addr, data, strb 0.
  - rsp_valid 0; rsp_* 0; stat counters 0.
- All outputs are registered. Nothing is combinational from input to output.
- Write against the register-file slave: accept at cycle N.
  - N+1: AWVALID and WVALID high.
  - N+2: AWREADY and WREADY high (both handshakes).
  - N+3: BVALID high.
  - N+4: rsp_valid high.
- Read against the register-file slave: accept at cycle N.
  - N+1: ARVALID high.
  - N+2: ARREADY high.
  - N+3: RVALID high.
  - N+4: rsp_valid high.
- Minimum command-to-command spacing is 5 cycles with rsp_ready held high. The next cmd_ready occurs one cycle after the rsp handshake.
- Reset asserted mid-transaction forces all outputs to their reset values immediately. No response is produced and the counters clear.
- Timeout fires on cycle N+TIMEOUT_CYCLES after accept; rsp_valid is high on the following cycle.

## Test plan
- Write 0xDEADBEEF, strb 0xF to addr 0x4 on the register-file slave, then read 0x4.
  - Write response: rsp_resp=0, rsp_write=1.
  - Read response: rsp_rdata=0xDEADBEEF.
  - rsp_valid at N+4 for both; stat_txn_count=2.
- Write 0x11223344 with strb 0x5 over an existing 0xFFFFFFFF, then read.
  - Readback = 0xFF22FF44.
- Stall the slave: delay AWREADY 3 cycles after WREADY.
  - AWVALID stays high alone; no duplicate W beat.
  - Response arrives after the B handshake with rsp_resp=0.
- Slave never responds, TIMEOUT_CYCLES=16.
  - rsp_valid at N+17 with rsp_resp=2'b10, rsp_timeout=1.
  - stat_err_count=1; all AXI valids low from N+17.
- Hold rsp_ready low 10 cycles.
  - Response fields stay stable; cmd_ready stays 0 throughout.
  - A new command is accepted the cycle after the rsp handshake.
- Assert M_AXI_ARESET while in WR_B.
  - All outputs reach reset values within the same cycle.
  - No rsp_valid; counters read 0.
